// File: rtl/edge_arb_pkg.sv
// Shared types and defaults for the edge event arbiter and its bench.
package edge_arb_pkg;

  localparam int N_CH_DEFAULT = 4;

  typedef enum logic {EVT_RISE, EVT_FELL} evt_kind_e;

  // One emitted event; chan is wide enough for the largest channel count (16).
  typedef struct packed {
    logic [3:0] chan;
    evt_kind_e  kind;
  } evt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
  import edge_arb_pkg::*;
#(
  parameter int  N_CH = N_CH_DEFAULT,
  localparam int CW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CW-1:0]   ptr,
  output logic [N_CH-1:0] gnt,
  output logic [CW-1:0]   gnt_idx,
  output logic            gnt_any
);

  // Scan channels starting at ptr, wrapping at N_CH; indices never exceed N_CH-1.
  always_comb begin : scan
    int c;
    c       = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      c = int'(ptr) + k;
      if (c >= N_CH) c = c - N_CH;
      if (!gnt_any && req[c]) begin
        gnt[c]  = 1'b1;
        gnt_idx = CW'(c);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Per-channel rise/fall edge detector with pending events drained
// round-robin onto a single valid/ready event port; sticky drop flags.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int  N_CH = N_CH_DEFAULT,
  localparam int CW   = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sig_i,
  input  logic [N_CH-1:0] rise_en,
  input  logic [N_CH-1:0] fall_en,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CW-1:0]   evt_chan,
  output logic            evt_kind,
  output logic [N_CH-1:0] ovf,
  input  logic            ovf_clr
);

  typedef enum logic {S_IDLE, S_HOLD} state_e;

  state_e          state;
  logic [N_CH-1:0] prev;
  logic            primed;
  logic [N_CH-1:0] pend_fall;
  logic [N_CH-1:0] pend_rise;
  logic [CW-1:0]   rr_ptr;

  logic [N_CH-1:0] rose;
  logic [N_CH-1:0] fell;
  logic [N_CH-1:0] req;
  logic [N_CH-1:0] gnt_oh;
  logic [CW-1:0]   gnt_idx;
  logic            gnt_any;
  logic            gnt_fall;
  logic            load;
  logic [N_CH-1:0] clr_fall;
  logic [N_CH-1:0] clr_rise;
  logic [N_CH-1:0] ovf_set;

  assign req = pend_fall | pend_rise;

  rr_arbiter #(.N_CH(N_CH)) u_rr (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Edge detection, grant decode and drop detection for this cycle.
  always_comb begin
    rose     = primed ? (~prev & sig_i & rise_en) : '0;
    fell     = primed ? (prev & ~sig_i & fall_en) : '0;
    // A new grant is taken whenever the output register is empty or being consumed.
    load     = gnt_any & ((state == S_IDLE) | evt_ready);
    // Fall has priority over rise within the granted channel.
    gnt_fall = |(gnt_oh & pend_fall);
    clr_fall = (load &  gnt_fall) ? gnt_oh : '0;
    clr_rise = (load & ~gnt_fall) ? gnt_oh : '0;
    // Drop only when the bit stays pending this cycle; a same-cycle grant frees the slot.
    ovf_set  = (fell & pend_fall & ~clr_fall) | (rose & pend_rise & ~clr_rise);
  end

  // Sampling history, pending bits and sticky overflow flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev      <= '0;
      primed    <= 1'b0;
      pend_fall <= '0;
      pend_rise <= '0;
      ovf       <= '0;
    end else begin
      prev      <= sig_i;
      primed    <= 1'b1;
      pend_fall <= (pend_fall & ~clr_fall) | fell;
      pend_rise <= (pend_rise & ~clr_rise) | rose;
      ovf       <= (ovf & ~{N_CH{ovf_clr}}) | ovf_set;
    end
  end

  // Output register FSM: IDLE waits for a pending bit, HOLD presents it until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      evt_valid <= 1'b0;
      evt_chan  <= '0;
      evt_kind  <= EVT_RISE;
      rr_ptr    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load) begin
            evt_chan  <= gnt_idx;
            evt_kind  <= gnt_fall ? EVT_FELL : EVT_RISE;
            evt_valid <= 1'b1;
            rr_ptr    <= (gnt_idx == CW'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (load) begin
            evt_chan  <= gnt_idx;
            evt_kind  <= gnt_fall ? EVT_FELL : EVT_RISE;
            rr_ptr    <= (gnt_idx == CW'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
          end else if (evt_ready) begin
            evt_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          evt_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomized and directed bench for edge_event_arbiter against an
// event-level reference model of pending sets and a rotating scheduler.
module tb_edge_event_arbiter;
  import edge_arb_pkg::*;

  localparam int N  = N_CH_DEFAULT;
  localparam int CW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  sig_i;
  logic [N-1:0]  rise_en;
  logic [N-1:0]  fall_en;
  logic          evt_valid;
  logic          evt_ready;
  logic [CW-1:0] evt_chan;
  logic          evt_kind;
  logic [N-1:0]  ovf;
  logic          ovf_clr;

  int checks   = 0;
  int failures = 0;

  edge_event_arbiter #(.N_CH(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_i     (sig_i),
    .rise_en   (rise_en),
    .fall_en   (fall_en),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_chan  (evt_chan),
    .evt_kind  (evt_kind),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference model: sets of outstanding edges per channel and kind.
  bit   m_prev [N];
  bit   m_pf   [N];
  bit   m_pr   [N];
  bit   m_ovf  [N];
  bit   m_primed;
  int   m_ptr;
  bit   m_valid;
  evt_t m_evt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_prev[i] = 0; m_pf[i] = 0; m_pr[i] = 0; m_ovf[i] = 0;
    end
    m_primed = 0;
    m_ptr    = 0;
    m_valid  = 0;
    m_evt    = '0;
  endtask

  // One clock of the model, using the inputs present at the edge.
  task automatic model_step();
    bit f [N];
    bit r [N];
    int g;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      f[i] = m_primed &&  m_prev[i] && !sig_i[i] && fall_en[i];
      r[i] = m_primed && !m_prev[i] &&  sig_i[i] && rise_en[i];
    end
    g = -1;
    if (!m_valid || evt_ready) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (m_pf[c] || m_pr[c]) begin
          g = c;
          break;
        end
      end
    end
    if (g >= 0) begin
      m_evt.chan = 4'(g);
      if (m_pf[g]) begin
        m_evt.kind = EVT_FELL;
        m_pf[g] = 0;
      end else begin
        m_evt.kind = EVT_RISE;
        m_pr[g] = 0;
      end
      m_valid = 1;
      m_ptr   = (g + 1) % N;
    end else if (m_valid && evt_ready) begin
      m_valid = 0;
    end
    if (ovf_clr) for (int i = 0; i < N; i++) m_ovf[i] = 0;
    for (int i = 0; i < N; i++) begin
      if (f[i]) begin
        if (m_pf[i]) m_ovf[i] = 1;
        m_pf[i] = 1;
      end
      if (r[i]) begin
        if (m_pr[i]) m_ovf[i] = 1;
        m_pr[i] = 1;
      end
      m_prev[i] = sig_i[i];
    end
    m_primed = 1;
  endtask

  task automatic compare_outputs();
    logic [N-1:0] eo;
    for (int i = 0; i < N; i++) eo[i] = m_ovf[i];
    chk("evt_valid", 32'(evt_valid), 32'(m_valid));
    if (m_valid) begin
      chk("evt_chan", 32'(evt_chan), 32'(m_evt.chan));
      chk("evt_kind", 32'(evt_kind), 32'(m_evt.kind));
    end
    chk("ovf", 32'(ovf), 32'(eo));
  endtask

  // Advance one clock, update the model, then sample outputs after the edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_outputs();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset(input logic [N-1:0] sig_at_release);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_async_valid", 32'(evt_valid), 32'd0);
    chk("rst_async_ovf", 32'(ovf), 32'd0);
    sig_i = sig_at_release;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    sig_i     = '0;
    rise_en   = '1;
    fall_en   = '1;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;
    model_reset();
    cycle();
    chk("reset_valid", 32'(evt_valid), 32'd0);
    chk("reset_chan", 32'(evt_chan), 32'd0);
    chk("reset_kind", 32'(evt_kind), 32'd0);

    // Priming with all signals high: no spurious rise events.
    sig_i = '1;
    cycle();
    rst = 1'b0;
    cycles(4);
    chk("prime_no_evt", 32'(evt_valid), 32'd0);

    // Single fall on channel 0: valid two edges after the sampled edge.
    sig_i[0] = 1'b0;
    cycle();
    chk("fall0_pend_only", 32'(evt_valid), 32'd0);
    cycle();
    chk("fall0_valid", 32'(evt_valid), 32'd1);
    chk("fall0_chan", 32'(evt_chan), 32'd0);
    chk("fall0_kind", 32'(evt_kind), 32'(EVT_FELL));
    cycle();
    chk("fall0_single", 32'(evt_valid), 32'd0);

    // Simultaneous falls from a fresh pointer: chans 0..3 back to back.
    do_reset('1);
    cycles(2);
    sig_i = '0;
    cycle();
    for (int k = 0; k < N; k++) begin
      cycle();
      chk("simul_valid", 32'(evt_valid), 32'd1);
      chk("simul_chan", 32'(evt_chan), 32'(k));
    end
    cycle();
    chk("simul_done", 32'(evt_valid), 32'd0);
    // Pointer back at 0: a fall on chan 0 and chan 3 together serves 0 first.
    sig_i = '1;
    cycles(6);
    sig_i[0] = 1'b0; sig_i[3] = 1'b0;
    cycles(2);
    chk("ptr_wrap_chan", 32'(evt_chan), 32'd0);
    cycles(3);

    // Backpressure and overflow on channel 2.
    sig_i = '1;
    cycles(6);
    evt_ready = 1'b0;
    sig_i[2] = 1'b0; cycle();
    sig_i[2] = 1'b1; cycle();
    sig_i[2] = 1'b0; cycle();
    sig_i[2] = 1'b1; cycle();
    sig_i[2] = 1'b0; cycle();
    cycles(2);
    chk("bp_chan_stable", 32'(evt_chan), 32'd2);
    chk("bp_kind_stable", 32'(evt_kind), 32'(EVT_FELL));
    chk("bp_ovf2", 32'(ovf[2]), 32'd1);
    ovf_clr = 1'b1; cycle();
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(ovf), 32'd0);
    evt_ready = 1'b1;
    cycles(4);

    // Fall beats rise on channel 1 while the output is held by channel 0.
    sig_i = 4'b1101;
    cycles(4);
    evt_ready = 1'b0;
    sig_i[0] = 1'b0; cycles(2);
    sig_i[1] = 1'b1; cycle();
    sig_i[1] = 1'b0; cycle();
    evt_ready = 1'b1;
    cycle();
    chk("fbr_first_kind", 32'(evt_kind), 32'(EVT_FELL));
    chk("fbr_first_chan", 32'(evt_chan), 32'd1);
    cycle();
    chk("fbr_second_kind", 32'(evt_kind), 32'(EVT_RISE));
    chk("fbr_second_chan", 32'(evt_chan), 32'd1);
    cycles(3);

    // Enable gating on channel 3.
    sig_i = '1;
    cycles(4);
    fall_en[3] = 1'b0;
    sig_i[3] = 1'b0; cycles(3);
    chk("gate_no_fall", 32'(evt_valid), 32'd0);
    sig_i[3] = 1'b1; cycles(2);
    chk("gate_rise_chan", 32'(evt_chan), 32'd3);
    chk("gate_rise_kind", 32'(evt_kind), 32'(EVT_RISE));
    fall_en = '1;
    cycles(3);

    // Reset during HOLD with further events pending.
    evt_ready = 1'b0;
    sig_i = '0;
    cycles(3);
    do_reset('1);
    evt_ready = 1'b1;
    cycles(5);
    chk("post_rst_quiet", 32'(evt_valid), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      sig_i     = N'($urandom);
      evt_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) rise_en = N'($urandom);
      if ($urandom_range(0, 31) == 0) fall_en = N'($urandom);
      if ($urandom_range(0, 199) == 0) do_reset(N'($urandom));
      else cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
